// File: rtl/ldpc_pkg.sv
// Shared constants and helpers for the LDPC message datapath.
package ldpc_pkg;

    // Default soft-message width: one sign bit plus four magnitude bits.
    localparam int unsigned MsgWidth = 5;

    function automatic int unsigned mag_width(input int unsigned w);
        return w - 1;
    endfunction

endpackage

// File: rtl/sm2tc_lane.sv
// Combinational sign-magnitude to two's-complement converter for one word.
module sm2tc_lane
    import ldpc_pkg::*;
#(
    parameter int unsigned W = MsgWidth
) (
    input  logic [W-1:0] in_word,
    output logic [W-1:0] out_word
);

    localparam int unsigned M = mag_width(W);

    logic         sign;
    logic [M-1:0] mag;
    logic [W-1:0] mag_ext;
    logic [W-1:0] mag_neg;

    assign sign    = in_word[W-1];
    assign mag     = in_word[M-1:0];
    assign mag_ext = {1'b0, mag};
    assign mag_neg = ~mag_ext + W'(1);

    // Negative zero maps to zero, so the most-negative code is never produced.
    always_comb begin
        out_word = mag_ext;
        if (sign && (mag != '0)) begin
            out_word = mag_neg;
        end
    end

endmodule

// File: rtl/sign_mag_to_twos.sv
// Converts LANES packed sign-magnitude words to two's complement with one register stage.
module sign_mag_to_twos
    import ldpc_pkg::*;
#(
    parameter int unsigned W     = MsgWidth,
    parameter int unsigned LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [W*LANES-1:0] in_data,
    output logic               out_valid,
    output logic [W*LANES-1:0] out_data
);

    logic [W*LANES-1:0] conv_data;
    logic               valid_d, valid_q;
    logic [W*LANES-1:0] data_d, data_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sm2tc_lane #(
            .W(W)
        ) u_lane (
            .in_word (in_data[i*W +: W]),
            .out_word(conv_data[i*W +: W])
        );
    end

    // Data holds while the input is idle.
    always_comb begin
        valid_d = in_valid;
        data_d  = data_q;
        if (in_valid) begin
            data_d = conv_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_sign_mag_to_twos.sv
// Self-checking bench: single-lane and four-lane instances against an arithmetic reference model.
module tb_sign_mag_to_twos;

    localparam int unsigned W = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid1, in_valid4;
    logic [4:0]  in_data1;
    logic [19:0] in_data4;
    logic        out_valid1, out_valid4;
    logic [4:0]  out_data1;
    logic [19:0] out_data4;

    int n_checks = 0;
    int n_errors = 0;

    logic        mv;
    logic [4:0]  md1;
    logic [19:0] md4;

    always #5 clk = ~clk;

    sign_mag_to_twos #(.W(W), .LANES(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .in_data  (in_data1),
        .out_valid(out_valid1),
        .out_data (out_data1)
    );

    sign_mag_to_twos #(.W(W), .LANES(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid4),
        .in_data  (in_data4),
        .out_valid(out_valid4),
        .out_data (out_data4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signed value s ? -m : m, reduced modulo 2^W.
    function automatic logic [4:0] ref_conv(input logic [4:0] x);
        int m, v;
        m = int'(x[3:0]);
        v = x[4] ? -m : m;
        v = ((v % 32) + 32) % 32;
        return 5'(v);
    endfunction

    // Drive one cycle on both instances, update the model, compare all outputs.
    task automatic cycle(input logic r, input logic v, input logic [4:0] d1,
                         input logic [19:0] d4);
        rst       = r;
        in_valid1 = v;
        in_valid4 = v;
        in_data1  = d1;
        in_data4  = d4;
        @(posedge clk);
        #1;
        if (r) begin
            mv  = 1'b0;
            md1 = '0;
            md4 = '0;
        end else begin
            mv = v;
            if (v) begin
                md1 = ref_conv(d1);
                for (int i = 0; i < 4; i++) md4[i*5 +: 5] = ref_conv(d4[i*5 +: 5]);
            end
        end
        check("valid1", 32'(out_valid1), 32'(mv));
        check("data1", 32'(out_data1), 32'(md1));
        check("valid4", 32'(out_valid4), 32'(mv));
        check("data4", 32'(out_data4), 32'(md4));
    endtask

    logic [4:0] tp_in  [9];
    logic [4:0] tp_out [9];

    initial begin
        tp_in[0] = 5'b10010; tp_out[0] = 5'b11110;
        tp_in[1] = 5'b10101; tp_out[1] = 5'b11011;
        tp_in[2] = 5'b11010; tp_out[2] = 5'b10110;
        tp_in[3] = 5'b00100; tp_out[3] = 5'b00100;
        tp_in[4] = 5'b10000; tp_out[4] = 5'b00000;
        tp_in[5] = 5'b11111; tp_out[5] = 5'b10001;
        tp_in[6] = 5'b01111; tp_out[6] = 5'b01111;
        tp_in[7] = 5'b00000; tp_out[7] = 5'b00000;
        tp_in[8] = 5'b10001; tp_out[8] = 5'b11111;

        rst = 1'b1; in_valid1 = 1'b0; in_valid4 = 1'b0; in_data1 = '0; in_data4 = '0;
        md1 = '0; md4 = '0; mv = 1'b0;

        // Reset state
        cycle(1'b1, 1'b0, 5'b00000, 20'h0);
        cycle(1'b1, 1'b0, 5'b00000, 20'h0);

        // Directed vectors back to back, with fixed expected codes
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, tp_in[i], {4{tp_in[i]}});
            check("tp_data", 32'(out_data1), 32'(tp_out[i]));
            check("tp_valid", 32'(out_valid1), 32'd1);
        end

        // Reset overrides a valid input
        cycle(1'b1, 1'b1, 5'b11010, {4{5'b11010}});
        check("rst_data", 32'(out_data1), 32'd0);
        cycle(1'b0, 1'b1, 5'b11010, {4{5'b11010}});
        check("post_rst", 32'(out_data1), 32'(5'b10110));

        // Valid gating holds data
        cycle(1'b0, 1'b1, 5'b10101, 20'h0);
        cycle(1'b0, 1'b0, 5'b00111, 20'hfffff);
        check("hold_data", 32'(out_data1), 32'(5'b11011));

        // Lane packing
        cycle(1'b0, 1'b1, 5'b0, {5'b00100, 5'b11010, 5'b10101, 5'b10010});
        check("lanes", 32'(out_data4), 32'({5'b00100, 5'b10110, 5'b11011, 5'b11110}));

        // Exhaustive sweep; most-negative code must never appear
        for (int x = 0; x < 32; x++) begin
            cycle(1'b0, 1'b1, 5'(x), 20'($urandom));
            check("not_min", 32'(out_data1 == 5'b10000), 32'd0);
        end

        // Random traffic with occasional reset
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom), 20'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sign_mag_to_twos.md
Name: sign_mag_to_twos

Overview:
- Converts LDPC soft messages from sign-magnitude (S) to two's-complement (T) format.
- Used between check-node processing (sign-magnitude) and variable-node adders (two's complement).
- Processes LANES independent words per cycle.
- Output is registered with a valid qualifier, giving one cycle of latency.

Parameters:
- W, 5, word width in bits; MSB is the sign, W-1 LSBs are the magnitude; legal range 2..16.
- LANES, 1, number of parallel words converted per cycle; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  in_data holds valid words this cycle.
- in_data  input  W*LANES  sign-magnitude words; lane i occupies bits [i*W +: W].
- out_valid  output  1  out_data holds converted words.
- out_data  output  W*LANES  two's-complement words, same lane packing as in_data.

Behaviour:
- Reset: when rst=1 at a rising edge, out_valid<=0 and out_data<=0. rst has priority over in_valid.
- Latency:
  - out_valid(t+1) = in_valid(t).
  - out_data(t+1) = conv(in_data(t)) when in_valid(t)=1.
  - When in_valid(t)=0, out_data holds its previous value.
- No backpressure: every valid input produces a valid output exactly one cycle later, with no bubbles and no stalls. Back-to-back valid inputs give back-to-back outputs.
- Per-lane conversion conv(x), with s = x[W-1] and m = x[W-2:0]:
  - s=0: result = {1'b0, m}, i.e. unchanged.
  - s=1 and m!=0: result = two's-complement negation of zero-extended m, i.e. (~{1'b0,m}) + 1, truncated to W bits.
  - s=1 and m=0 (negative zero): result = all zeros. It must not produce the most-negative code.
- Range: outputs lie in [-(2^(W-1)-1), +(2^(W-1)-1)]. The code 1000..0 (most negative) is never generated.
- Lanes are fully independent. No carry or state is shared between lanes.
- Reset asserted mid-stream: any word captured in the same cycle is discarded, and out_valid is 0 on the following cycle.
- The conversion itself is purely combinational, with a single register stage at the output.

Decomposition:
- Shared package (ldpc_pkg):
  - constant for the default message width W=5.
  - a helper function or constant for the magnitude width (W-1).
- Sub-module: sm2tc_lane. It is the combinational single-word converter (parameter W; ports in_word, out_word).
  - The top instantiates LANES copies in a generate loop.
  - The top adds the valid/data output register and the reset logic.

Test Plan:
1. W=5, LANES=1: drive in_valid=1 with 10010, 10101, 11010, 00100 on consecutive cycles -> out_data is 11110, 11011, 10110, 00100 one cycle after each input, with out_valid=1 for four consecutive cycles.
2. Boundaries, W=5:
   - 10000 (negative zero) -> 00000.
   - 11111 (-15) -> 10001.
   - 01111 -> 01111.
   - 00000 -> 00000.
   - 10001 -> 11111.
3. Reset: hold rst=1 while in_valid=1 with 11010 -> out_valid=0 and out_data=00000 the next cycle. Release rst -> the next valid input appears normally after one cycle.
4. Valid gating: apply a valid 10101 -> output 11011. Then in_valid=0 with in_data=00111 -> out_valid=0 and out_data stays 11011.
5. LANES=4, W=5: in_data lanes {3:00100, 2:11010, 1:10101, 0:10010} -> out lanes {3:00100, 2:10110, 1:11011, 0:11110} in one cycle.
6. Exhaustive sweep, W=5: all 32 inputs -> each output equals the reference model (s ? -m : m) mod 32, and no output equals 10000.
